// File: rtl/m_pipe_reg.sv
// m_pipe_reg: Y86-64 Execute-to-Memory pipeline register with stall, bubble and exception freeze.
// Define M_REG_PERF_EN to build the stall/bubble cycle counters; without it those ports read 0.
module m_pipe_reg #(
    parameter int DATA_W        = 64,
    parameter int RID_W         = 4,
    parameter int ICODE_W       = 4,
    parameter int STAT_W        = 3,
    parameter int FREEZE_ON_EXC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               M_stall,
    input  logic               M_bubble,
    input  logic [STAT_W-1:0]  e_stat,
    input  logic [ICODE_W-1:0] e_icode,
    input  logic               e_Cnd,
    input  logic [DATA_W-1:0]  e_valE,
    input  logic [DATA_W-1:0]  e_valA,
    input  logic [RID_W-1:0]   e_dstE,
    input  logic [RID_W-1:0]   e_dstM,
    output logic [STAT_W-1:0]  M_stat,
    output logic [ICODE_W-1:0] M_icode,
    output logic               M_Cnd,
    output logic [DATA_W-1:0]  M_valE,
    output logic [DATA_W-1:0]  M_valA,
    output logic [RID_W-1:0]   M_dstE,
    output logic [RID_W-1:0]   M_dstM,
    output logic               M_valid,
    output logic               M_frozen,
    output logic               M_ctl_err,
    output logic [31:0]        M_stall_cnt,
    output logic [31:0]        M_bubble_cnt
);

    localparam logic [STAT_W-1:0]  SBUB  = STAT_W'(0);
    localparam logic [STAT_W-1:0]  SHLT  = STAT_W'(2);
    localparam logic [STAT_W-1:0]  SADR  = STAT_W'(3);
    localparam logic [STAT_W-1:0]  SINS  = STAT_W'(4);
    localparam logic [ICODE_W-1:0] INOP  = ICODE_W'(1);
    localparam logic [RID_W-1:0]   RNONE = {RID_W{1'b1}};

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

    // Control priority: freeze > bubble > stall > load. Exactly one take_* is high
    // on an unfrozen edge; none while frozen.
    logic take_bubble;
    logic take_stall;
    logic take_load;

    always_comb begin
        take_bubble = 1'b0;
        take_stall  = 1'b0;
        take_load   = 1'b0;
        if (!M_frozen) begin
            if (M_bubble)
                take_bubble = 1'b1;
            else if (M_stall)
                take_stall = 1'b1;
            else
                take_load = 1'b1;
        end
    end

    // Payload register; a stall or freeze simply leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_stat  <= SBUB;
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (take_bubble) begin
            M_stat  <= SBUB;
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (take_load) begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= e_dstM;
        end
    end

    // Flags a pipeline-control conflict seen on the most recent edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            M_ctl_err <= 1'b0;
        else
            M_ctl_err <= M_stall & M_bubble;
    end

    assign M_valid = (M_stat != SBUB);

    generate
        if (FREEZE_ON_EXC != 0) begin : g_freeze
            logic frozen_q;

            // Sticky until reset: once an exception reaches M the stage stops moving.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    frozen_q <= 1'b0;
                else if (take_load && is_exc(e_stat))
                    frozen_q <= 1'b1;
            end

            assign M_frozen = frozen_q;
        end else begin : g_no_freeze
            assign M_frozen = 1'b0;
        end
    endgenerate

`ifdef M_REG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Counters wrap naturally at 32 bits; take_* already excludes frozen edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (take_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (take_bubble)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign M_stall_cnt  = stall_cnt_q;
    assign M_bubble_cnt = bubble_cnt_q;
`else
    assign M_stall_cnt  = 32'd0;
    assign M_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_m_pipe_reg.sv
// Directed testbench for m_pipe_reg: reset, pass-through, stall, bubble, conflict, freeze, counters.
module tb_m_pipe_reg;

`ifdef M_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        M_stall;
    logic        M_bubble;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        M_valid;
    logic        M_frozen;
    logic        M_ctl_err;
    logic [31:0] M_stall_cnt;
    logic [31:0] M_bubble_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall_n = 0;
    int exp_bubble_n = 0;

    m_pipe_reg dut (
        .clk          (clk),
        .reset        (reset),
        .M_stall      (M_stall),
        .M_bubble     (M_bubble),
        .e_stat       (e_stat),
        .e_icode      (e_icode),
        .e_Cnd        (e_Cnd),
        .e_valE       (e_valE),
        .e_valA       (e_valA),
        .e_dstE       (e_dstE),
        .e_dstM       (e_dstM),
        .M_stat       (M_stat),
        .M_icode      (M_icode),
        .M_Cnd        (M_Cnd),
        .M_valE       (M_valE),
        .M_valA       (M_valA),
        .M_dstE       (M_dstE),
        .M_dstM       (M_dstM),
        .M_valid      (M_valid),
        .M_frozen     (M_frozen),
        .M_ctl_err    (M_ctl_err),
        .M_stall_cnt  (M_stall_cnt),
        .M_bubble_cnt (M_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle, so inputs change and outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        M_stall = 1'b0;
        M_bubble = 1'b0;
        e_stat = 3'd1; e_icode = 4'd6; e_Cnd = 1'b1;
        e_valE = 64'h1234; e_valA = 64'hABCD; e_dstE = 4'd2; e_dstM = 4'hF;
        #3;
        checks++;
        if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM} !== {3'd0, 4'd1, 1'b0, 4'hF, 4'hF}) begin
            errors++;
            $display("FAIL reset_bubble_ctl got stat=%0d icode=%0d cnd=%0b dstE=%h dstM=%h want 0 1 0 f f",
                     M_stat, M_icode, M_Cnd, M_dstE, M_dstM);
        end
        checks++;
        if ({M_valE, M_valA} !== 128'd0) begin
            errors++;
            $display("FAIL reset_vals got valE=%h valA=%h want 0 0", M_valE, M_valA);
        end
        checks++;
        if ({M_valid, M_frozen, M_ctl_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid=%b frozen=%b ctl_err=%b want 000", M_valid, M_frozen, M_ctl_err);
        end
        checks++;
        if ({M_stall_cnt, M_bubble_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt got stall=%0d bubble=%0d want 0 0", M_stall_cnt, M_bubble_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_stall_n = 0;
        exp_bubble_n = 0;
    endtask

    task automatic test_pass_through();
        tick();
        checks++;
        if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM} !== {3'd1, 4'd6, 1'b1, 4'd2, 4'hF}) begin
            errors++;
            $display("FAIL pass_ctl got stat=%0d icode=%0d cnd=%0b dstE=%h dstM=%h want 1 6 1 2 f",
                     M_stat, M_icode, M_Cnd, M_dstE, M_dstM);
        end
        checks++;
        if (M_valE !== 64'h1234 || M_valA !== 64'hABCD || M_valid !== 1'b1) begin
            errors++;
            $display("FAIL pass_vals got valE=%h valA=%h valid=%b want 1234 abcd 1", M_valE, M_valA, M_valid);
        end
        // Full-width copy check on the data paths.
        e_valE = 64'hF00D_0000_0000_0001; e_valA = 64'h8000_0000_0000_0000; e_dstE = 4'hE; e_dstM = 4'h3;
        tick();
        checks++;
        if (M_valE !== 64'hF00D_0000_0000_0001 || M_valA !== 64'h8000_0000_0000_0000
            || M_dstE !== 4'hE || M_dstM !== 4'h3) begin
            errors++;
            $display("FAIL pass_wide got valE=%h valA=%h dstE=%h dstM=%h want f00d000000000001 8000000000000000 e 3",
                     M_valE, M_valA, M_dstE, M_dstM);
        end
    endtask

    task automatic test_stall();
        e_valE = 64'h10;
        tick();
        e_valE = 64'h20;
        M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_stall_n++;
        end
        M_stall = 1'b0;
        checks++;
        if (M_valE !== 64'h10) begin
            errors++;
            $display("FAIL stall_hold got valE=%h want 10", M_valE);
        end
        checks++;
        if (M_stall_cnt !== (PERF ? 32'(exp_stall_n) : 32'd0)) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d", M_stall_cnt, PERF ? exp_stall_n : 0);
        end
        tick();
        checks++;
        if (M_valE !== 64'h20) begin
            errors++;
            $display("FAIL stall_release got valE=%h want 20", M_valE);
        end
    endtask

    task automatic test_bubble();
        e_stat = 3'd1; e_icode = 4'd5; e_valE = 64'h77; e_dstE = 4'd1; e_dstM = 4'd2;
        tick();
        checks++;
        if (M_icode !== 4'd5) begin
            errors++;
            $display("FAIL bubble_pre got icode=%0d want 5", M_icode);
        end
        M_bubble = 1'b1;
        tick();
        exp_bubble_n++;
        M_bubble = 1'b0;
        checks++;
        if ({M_stat, M_icode, M_dstE, M_dstM, M_valE, M_valid} !== {3'd0, 4'd1, 4'hF, 4'hF, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL bubble_load got stat=%0d icode=%0d dstE=%h dstM=%h valE=%h valid=%b want 0 1 f f 0 0",
                     M_stat, M_icode, M_dstE, M_dstM, M_valE, M_valid);
        end
        checks++;
        if (M_bubble_cnt !== (PERF ? 32'(exp_bubble_n) : 32'd0) || M_ctl_err !== 1'b0) begin
            errors++;
            $display("FAIL bubble_cnt got cnt=%0d ctl_err=%b want %0d 0", M_bubble_cnt, M_ctl_err,
                     PERF ? exp_bubble_n : 0);
        end
    endtask

    task automatic test_conflict();
        e_stat = 3'd1; e_icode = 4'd3; e_valE = 64'h42;
        tick();
        M_stall = 1'b1;
        M_bubble = 1'b1;
        tick();
        exp_bubble_n++;
        M_stall = 1'b0;
        M_bubble = 1'b0;
        checks++;
        if (M_stat !== 3'd0 || M_valE !== 64'd0 || M_ctl_err !== 1'b1) begin
            errors++;
            $display("FAIL conflict_edge got stat=%0d valE=%h ctl_err=%b want 0 0 1", M_stat, M_valE, M_ctl_err);
        end
        checks++;
        if (M_stall_cnt !== (PERF ? 32'(exp_stall_n) : 32'd0)
            || M_bubble_cnt !== (PERF ? 32'(exp_bubble_n) : 32'd0)) begin
            errors++;
            $display("FAIL conflict_cnt got stall=%0d bubble=%0d want %0d %0d", M_stall_cnt, M_bubble_cnt,
                     PERF ? exp_stall_n : 0, PERF ? exp_bubble_n : 0);
        end
        tick();
        checks++;
        if (M_ctl_err !== 1'b0 || M_stat !== 3'd1 || M_valE !== 64'h42) begin
            errors++;
            $display("FAIL conflict_clear got ctl_err=%b stat=%0d valE=%h want 0 1 42", M_ctl_err, M_stat, M_valE);
        end
    endtask

    task automatic test_freeze();
        e_stat = 3'd3; e_icode = 4'd5; e_valE = 64'h55;
        tick();
        checks++;
        if (M_stat !== 3'd3 || M_frozen !== 1'b1 || M_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_set got stat=%0d frozen=%b valid=%b want 3 1 1", M_stat, M_frozen, M_valid);
        end
        e_stat = 3'd1; e_valE = 64'h99;
        tick();
        tick();
        M_bubble = 1'b1;
        tick();
        M_bubble = 1'b0;
        M_stall = 1'b1;
        tick();
        M_stall = 1'b0;
        checks++;
        if (M_stat !== 3'd3 || M_valE !== 64'h55 || M_icode !== 4'd5 || M_frozen !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold got stat=%0d valE=%h icode=%0d frozen=%b want 3 55 5 1",
                     M_stat, M_valE, M_icode, M_frozen);
        end
        checks++;
        if (M_stall_cnt !== (PERF ? 32'(exp_stall_n) : 32'd0)
            || M_bubble_cnt !== (PERF ? 32'(exp_bubble_n) : 32'd0)) begin
            errors++;
            $display("FAIL freeze_cnt got stall=%0d bubble=%0d want %0d %0d", M_stall_cnt, M_bubble_cnt,
                     PERF ? exp_stall_n : 0, PERF ? exp_bubble_n : 0);
        end
        // Asynchronous reset in the middle of a cycle, with no clock edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({M_stat, M_icode, M_valE, M_dstE, M_dstM, M_frozen, M_valid} !==
            {3'd0, 4'd1, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL freeze_reset got stat=%0d icode=%0d valE=%h dstE=%h dstM=%h frozen=%b valid=%b",
                     M_stat, M_icode, M_valE, M_dstE, M_dstM, M_frozen, M_valid);
        end
        checks++;
        if ({M_stall_cnt, M_bubble_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL freeze_reset_cnt got stall=%0d bubble=%0d want 0 0", M_stall_cnt, M_bubble_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_stall_n = 0;
        exp_bubble_n = 0;
        tick();
        checks++;
        if (M_stat !== 3'd1 || M_valE !== 64'h99 || M_frozen !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got stat=%0d valE=%h frozen=%b want 1 99 0", M_stat, M_valE, M_frozen);
        end
    endtask

`ifdef M_REG_PERF_EN
    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        M_bubble = 1'b1;
        tick();
        M_bubble = 1'b0;
        checks++;
        if (M_bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL counter_wrap got %h want 0", M_bubble_cnt);
        end
        M_stall = 1'b1;
        tick();
        M_stall = 1'b0;
        checks++;
        if (M_stall_cnt !== 32'd1 || M_bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL counter_after_wrap got stall=%0d bubble=%0d want 1 0", M_stall_cnt, M_bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_bubble();
        test_conflict();
        test_freeze();
`ifdef M_REG_PERF_EN
        test_counter_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
